// File: rtl/demorgan_sweep_checker.sv
// Initiator/checker for a two-input AND/NAND gate pair: sweeps A/B through all
// four vectors, samples both responses after a settle window and logs mismatches.
module demorgan_sweep_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       and_in,
    input  logic       nand_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec,
    output logic       sample_valid,
    output logic [1:0] sample_idx,
    output logic       sample_ok
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_vidx,  w_vidx_nxt;
    logic [3:0] r_cnt,   w_cnt_nxt;
    logic [1:0] r_ab,    w_ab_nxt;
    logic       r_busy,  w_busy_nxt;
    logic       r_done,  w_done_nxt;
    logic       r_pass,  w_pass_nxt;
    logic [2:0] r_err,   w_err_nxt;
    logic [3:0] r_fail,  w_fail_nxt;
    logic       r_sv,    w_sv_nxt;
    logic [1:0] r_sidx,  w_sidx_nxt;
    logic       r_sok,   w_sok_nxt;

    logic       w_and_exp;
    logic       w_match;
    logic [2:0] w_err_sum;

    // Case equality makes an X/Z response count as a mismatch in simulation.
    assign w_and_exp = r_ab[1] & r_ab[0];
    assign w_match   = (and_in === w_and_exp) && (nand_in === ~w_and_exp);
    assign w_err_sum = r_err + {2'b00, ~w_match};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_vidx  <= 2'd0;
            r_cnt   <= 4'd0;
            r_ab    <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 3'd0;
            r_fail  <= 4'd0;
            r_sv    <= 1'b0;
            r_sidx  <= 2'd0;
            r_sok   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vidx  <= w_vidx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ab    <= w_ab_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
            r_err   <= w_err_nxt;
            r_fail  <= w_fail_nxt;
            r_sv    <= w_sv_nxt;
            r_sidx  <= w_sidx_nxt;
            r_sok   <= w_sok_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vidx_nxt  = r_vidx;
        w_cnt_nxt   = r_cnt;
        w_ab_nxt    = r_ab;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = r_pass;
        w_err_nxt   = r_err;
        w_fail_nxt  = r_fail;
        w_sv_nxt    = 1'b0;
        w_sidx_nxt  = r_sidx;
        w_sok_nxt   = r_sok;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_busy_nxt  = 1'b1;
                    w_vidx_nxt  = 2'd0;
                    w_cnt_nxt   = 4'd0;
                    w_ab_nxt    = 2'b00;
                    w_err_nxt   = 3'd0;
                    w_fail_nxt  = 4'd0;
                    w_pass_nxt  = 1'b0;
                end
            end
            ST_RUN: begin
                if (r_cnt != SETTLE_C) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end else begin
                    w_sv_nxt   = 1'b1;
                    w_sidx_nxt = r_vidx;
                    w_sok_nxt  = w_match;
                    w_err_nxt  = w_err_sum;
                    if (!w_match) begin
                        w_fail_nxt[r_vidx] = 1'b1;
                    end
                    if (r_vidx != 2'd3) begin
                        w_vidx_nxt = r_vidx + 2'd1;
                        w_ab_nxt   = r_vidx + 2'd1;
                        w_cnt_nxt  = 4'd0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_ab_nxt    = 2'b00;
                        w_pass_nxt  = (w_err_sum == 3'd0);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign a            = r_ab[1];
    assign b            = r_ab[0];
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign err_count    = r_err;
    assign fail_vec     = r_fail;
    assign sample_valid = r_sv;
    assign sample_idx   = r_sidx;
    assign sample_ok    = r_sok;

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Bench for demorgan_sweep_checker: two instances (settle 1 and 0) driving a gate
// model with per-vector fault masks, checked cycle by cycle against a timing model.
module tb_demorgan_sweep_checker;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic chk_en = 1'b0;

    logic       start  [2];
    logic [3:0] m_and  [2];
    logic [3:0] m_nand [2];

    logic       a_o [2], b_o [2], and_i [2], nand_i [2];
    logic       busy_o [2], done_o [2], pass_o [2], sv_o [2], sok_o [2];
    logic [2:0] err_o [2];
    logic [3:0] fail_o [2];
    logic [1:0] sidx_o [2];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Gate under test: correct AND/NAND, each output flipped where its mask bit for the current vector is set.
    assign and_i[0]  =  (a_o[0] & b_o[0]) ^ m_and[0][{a_o[0], b_o[0]}];
    assign nand_i[0] = ~(a_o[0] & b_o[0]) ^ m_nand[0][{a_o[0], b_o[0]}];
    assign and_i[1]  =  (a_o[1] & b_o[1]) ^ m_and[1][{a_o[1], b_o[1]}];
    assign nand_i[1] = ~(a_o[1] & b_o[1]) ^ m_nand[1][{a_o[1], b_o[1]}];

    demorgan_sweep_checker #(.SETTLE(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .a(a_o[0]), .b(b_o[0]),
        .and_in(and_i[0]), .nand_in(nand_i[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .err_count(err_o[0]), .fail_vec(fail_o[0]),
        .sample_valid(sv_o[0]), .sample_idx(sidx_o[0]), .sample_ok(sok_o[0])
    );

    demorgan_sweep_checker #(.SETTLE(0)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .a(a_o[1]), .b(b_o[1]),
        .and_in(and_i[1]), .nand_in(nand_i[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .err_count(err_o[1]), .fail_vec(fail_o[1]),
        .sample_valid(sv_o[1]), .sample_idx(sidx_o[1]), .sample_ok(sok_o[1])
    );

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, d, $time, got, exp);
        end
    endtask

    function automatic int period(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // Reference model: a sweep is a run of 4*period edges after acceptance; vector k
    // is sampled on edge (k+1)*period and the stimulus shown is floor(phase/period).
    bit         run   [2];
    int         ph    [2];
    logic [1:0] e_ab  [2];
    logic       e_done[2], e_sv[2], e_sok[2], e_pass[2];
    logic [1:0] e_sidx[2];
    int         e_err [2];
    logic [3:0] e_fail[2];

    always @(posedge clk or posedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                run[d] = 0; ph[d] = 0; e_ab[d] = 2'b00; e_done[d] = 0; e_sv[d] = 0;
                e_sok[d] = 0; e_pass[d] = 0; e_sidx[d] = 2'd0; e_err[d] = 0; e_fail[d] = 4'd0;
            end else begin
                e_done[d] = 0;
                e_sv[d]   = 0;
                if (!run[d]) begin
                    if (start[d] === 1'b1) begin
                        run[d] = 1; ph[d] = 0; e_err[d] = 0; e_fail[d] = 4'd0; e_pass[d] = 0;
                    end
                end else begin
                    ph[d]++;
                    if (ph[d] % period(d) == 0) begin
                        int  k;
                        bit  bad;
                        k   = ph[d] / period(d) - 1;
                        bad = m_and[d][k] | m_nand[d][k];
                        e_sv[d]   = 1;
                        e_sidx[d] = 2'(k);
                        e_sok[d]  = !bad;
                        if (bad) begin
                            e_fail[d][k] = 1'b1;
                            e_err[d]++;
                        end
                        if (k == 3) begin
                            run[d]    = 0;
                            e_done[d] = 1;
                            e_pass[d] = (e_err[d] == 0);
                        end
                    end
                end
                e_ab[d] = run[d] ? 2'(ph[d] / period(d)) : 2'b00;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("a",            d, 32'(a_o[d]),    32'(e_ab[d][1]));
                chk("b",            d, 32'(b_o[d]),    32'(e_ab[d][0]));
                chk("busy",         d, 32'(busy_o[d]), 32'(run[d]));
                chk("done",         d, 32'(done_o[d]), 32'(e_done[d]));
                chk("pass",         d, 32'(pass_o[d]), 32'(e_pass[d]));
                chk("err_count",    d, 32'(err_o[d]),  32'(e_err[d]));
                chk("fail_vec",     d, 32'(fail_o[d]), 32'(e_fail[d]));
                chk("sample_valid", d, 32'(sv_o[d]),   32'(e_sv[d]));
                chk("sample_idx",   d, 32'(sidx_o[d]), 32'(e_sidx[d]));
                chk("sample_ok",    d, 32'(sok_o[d]),  32'(e_sok[d]));
            end
        end
    end

    // One full sweep on instance d with the given fault masks; optionally re-pulses start mid-sweep.
    task automatic sweep(input int d, input logic [3:0] ma, input logic [3:0] mn, input bit rep, output int lat);
        int n;
        @(negedge clk);
        #1;
        m_and[d]  = ma;
        m_nand[d] = mn;
        start[d]  = 1'b1;
        @(negedge clk);
        #1 start[d] = 1'b0;
        n = 0;
        while (done_o[d] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            #1 start[d] = (rep && (n == 2 || n == 5));
        end
        start[d] = 1'b0;
        lat = n;
        chk("latency",      d, 32'(n),            32'(4 * period(d)));
        chk("end_fail_vec", d, 32'(fail_o[d]),    32'(ma | mn));
        chk("end_err",      d, 32'(err_o[d]),     32'($countones(ma | mn)));
        chk("end_pass",     d, 32'(pass_o[d]),    32'((ma | mn) == 4'd0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; m_and[d] = 4'd0; m_nand[d] = 4'd0;
        end
        #1 reset = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", d, 32'(busy_o[d]), 32'd0);
            chk("rst_pass", d, 32'(pass_o[d]), 32'd0);
            chk("rst_err",  d, 32'(err_o[d]),  32'd0);
            chk("rst_fail", d, 32'(fail_o[d]), 32'd0);
        end
        #1 reset = 1'b0;

        // Correct gate, SETTLE=1.
        sweep(0, 4'b0000, 4'b0000, 1'b0, lat);
        chk("lit_lat8", 0, 32'(lat), 32'd8);
        chk("lit_pass", 0, 32'(pass_o[0]), 32'd1);

        // AND stuck at 0: only vector 3 fails.
        sweep(0, 4'b1000, 4'b0000, 1'b0, lat);
        chk("lit_stuck_fail", 0, 32'(fail_o[0]), 32'h8);
        chk("lit_stuck_err",  0, 32'(err_o[0]),  32'd1);
        chk("lit_stuck_pass", 0, 32'(pass_o[0]), 32'd0);

        // NAND wired to AND: every vector fails, then a clean sweep recovers.
        sweep(0, 4'b0000, 4'b1111, 1'b0, lat);
        chk("lit_all_fail", 0, 32'(fail_o[0]), 32'hF);
        chk("lit_all_err",  0, 32'(err_o[0]),  32'd4);
        sweep(0, 4'b0000, 4'b0000, 1'b0, lat);
        chk("lit_recover_pass", 0, 32'(pass_o[0]), 32'd1);

        // start re-pulsed while busy is ignored.
        sweep(0, 4'b0000, 4'b0000, 1'b1, lat);
        chk("lit_repulse_lat", 0, 32'(lat), 32'd8);

        // Asynchronous reset at vector 2 of a failing sweep.
        @(negedge clk);
        #1 m_and[0] = 4'b0000; m_nand[0] = 4'b1111; start[0] = 1'b1;
        @(negedge clk);
        #1 start[0] = 1'b0;
        n = 0;
        while (!(a_o[0] === 1'b1 && b_o[0] === 1'b0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_vidx2", 0, 32'(n < 20), 32'd1);
        chk("lit_mid_err", 0, 32'(err_o[0]), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("async_a",    0, 32'(a_o[0]),    32'd0);
        chk("async_err",  0, 32'(err_o[0]),  32'd0);
        chk("async_fail", 0, 32'(fail_o[0]), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        sweep(0, 4'b0000, 4'b0000, 1'b0, lat);
        chk("lit_post_rst_pass", 0, 32'(pass_o[0]), 32'd1);

        // SETTLE=0 instance.
        sweep(1, 4'b0000, 4'b0000, 1'b0, lat);
        chk("lit_lat4", 1, 32'(lat), 32'd4);

        // start held high through done: back-to-back sweep clears results.
        @(negedge clk);
        #1 m_and[1] = 4'b0000; m_nand[1] = 4'b1111; start[1] = 1'b1;
        n = 0;
        while (done_o[1] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", 1, 32'(n < 20), 32'd1);
        chk("lit_b2b_err4",  1, 32'(err_o[1]), 32'd4);
        @(negedge clk);
        chk("b2b_busy",  1, 32'(busy_o[1]), 32'd1);
        chk("b2b_clear", 1, 32'(err_o[1]),  32'd0);
        chk("b2b_fail",  1, 32'(fail_o[1]), 32'd0);
        #1 start[1] = 1'b0; m_nand[1] = 4'b0000;
        n = 0;
        while (done_o[1] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_second_done", 1, 32'(n < 20), 32'd1);
        chk("lit_b2b_pass",    1, 32'(pass_o[1]), 32'd1);

        // Random fault patterns on either instance.
        for (int i = 0; i < 30; i++) begin
            int         d;
            logic [3:0] ma, mn;
            d  = int'($urandom_range(1, 0));
            ma = 4'($urandom);
            mn = 4'($urandom);
            if ($urandom_range(2, 0) == 0) begin
                ma = 4'd0; mn = 4'd0;
            end
            sweep(d, ma, mn, 1'($urandom), lat);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
